ibuf_pingpong: RTL and testbench
================================

Name: ibuf_pingpong

Overview:
- Double-buffered, banked input buffer for the systolic array input path: NUM_BANKS independent lanes, each a 2*BANK_DEPTH x DATA_WIDTH simple dual-port memory split into two halves (ping/pong).
- The DDR fill side writes one half while the array read side consumes the other; halves swap through a done/ready handshake.
- Adds a broadcast write mode, per-bank read-valid tracking over a configurable read latency, and sticky overflow/underflow error flags.

Parameters:
NUM_BANKS, 64, number of banks/lanes
DATA_WIDTH, 8, bits per bank entry
BANK_DEPTH, 512, entries per bank per half (power of two)
ADDR_WIDTH, 9, log2(BANK_DEPTH); per-bank address width within a half
READ_LATENCY, 1, rd_req to rd_data/rd_valid latency in cycles; legal values 1 or 2

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
wr_req  in  NUM_BANKS  per-bank write enable
wr_addr  in  NUM_BANKS*ADDR_WIDTH  per-bank write address; lane n at [n*ADDR_WIDTH +: ADDR_WIDTH]
wr_data  in  NUM_BANKS*DATA_WIDTH  per-bank write data; lane n at [n*DATA_WIDTH +: DATA_WIDTH]
wr_broadcast  in  1  1: lane-0 address/data written to every bank whose wr_req bit is set
wr_done  in  1  pulse: writer finished filling current write half
wr_ready  out  1  current write half is free
wr_half  out  1  index of current write half
rd_req  in  NUM_BANKS  per-bank read enable
rd_addr  in  NUM_BANKS*ADDR_WIDTH  per-bank read address
rd_data  out  NUM_BANKS*DATA_WIDTH  per-bank read data
rd_valid  out  NUM_BANKS  per-bank read data valid
rd_done  in  1  pulse: reader finished with current read half
rd_ready  out  1  current read half holds filled data
rd_half  out  1  index of current read half
err_overflow  out  1  sticky: write or wr_done attempted while wr_ready=0
err_underflow  out  1  sticky: read or rd_done attempted while rd_ready=0

Behaviour:
- State per half: full[h] (0 = FREE, 1 = FILLED). Pointers: wr_ptr, rd_ptr.
- Outputs: wr_half = wr_ptr, rd_half = rd_ptr, wr_ready = !full[wr_ptr], rd_ready = full[rd_ptr].
- Reset (async assert, low): full = 2'b00; wr_ptr = rd_ptr = 0; rd_valid pipeline = 0; rd_data = 0; err flags = 0. Memory contents are not cleared.
- After reset: wr_ready = 1, rd_ready = 0. Reset mid-operation discards both halves and drops in-flight reads; rd_valid is 0 from the reset edge onward.
- Write: physical address {wr_ptr, addr}. Bank n is written iff wr_req[n] && wr_ready.
  - wr_broadcast=0: lane n uses its own addr/data.
  - wr_broadcast=1: all selected banks use lane-0 addr/data.
  - Writes with wr_ready=0 are dropped and set err_overflow.
- wr_done with wr_ready=1: full[wr_ptr] <= 1 and wr_ptr toggles at the next edge. wr_done with wr_ready=0 is ignored and sets err_overflow.
- Writes in the same cycle as wr_done land in the old half.
- Read: bank n is read at {rd_ptr, rd_addr_n} iff rd_req[n] && rd_ready.
  - READ_LATENCY=1: rd_data lane n and rd_valid[n] update at the next edge.
  - READ_LATENCY=2: one extra output register stage on both.
  - rd_valid[n] = 0 for any cycle without a qualifying read at the matching latency; rd_data holds its last value when not valid.
- Reads with rd_ready=0 return no valid and set err_underflow.
- rd_done with rd_ready=1: full[rd_ptr] <= 0 and rd_ptr toggles. Reads in the same cycle as rd_done use the old half, and their data still returns valid.
- rd_done with rd_ready=0 is ignored and sets err_underflow.
- wr_done and rd_done in the same cycle always target different halves; both updates apply.
- Read/write to the same physical location cannot occur: a FREE half is never read and a FILLED half is never written.
- Write-first/read-first semantics are therefore irrelevant.
- Error flags are cleared only by reset.

Test Plan:
- Reset, then write bank 3 addr 5 = 0xA5, pulse wr_done, read bank 3 addr 5 -> with READ_LATENCY=1, rd_data[31:24]=0xA5 and rd_valid[3]=1 one cycle later; all other rd_valid bits 0.
- Ping-pong overlap: fill half 0 with 0x11, wr_done; fill half 1 with 0x22 while reading half 0 -> reads return 0x11; after wr_done and rd_done, reads return 0x22 from half 1; no err flags set.
- Broadcast: wr_broadcast=1, wr_req=all ones, lane0 addr 7 data 0x3C, wr_done -> every bank reads 0x3C at addr 7.
- Back-pressure: two wr_done pulses with no rd_done -> wr_ready=0; a further write and a third wr_done are dropped and err_overflow=1; half 0 data is unchanged.
- Underflow: rd_req=all ones right after reset -> rd_valid stays 0 and err_underflow=1; READ_LATENCY=2 build -> valid data appears exactly two cycles after rd_req.
- Reset asserted during streaming reads -> rd_valid=0 immediately and wr_ready=1, rd_ready=0 after release.

Source files
------------

// File: rtl/ibuf_pingpong_if.sv
// Bus bundle for ibuf_pingpong: DDR fill side, array read side, handshakes and error flags.
// Lane n of each packed per-bank field sits at [n*WIDTH +: WIDTH].
interface ibuf_pingpong_if #(
  parameter int unsigned NUM_BANKS  = 64,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 9
);
  logic [NUM_BANKS-1:0]            wr_req;
  logic [NUM_BANKS*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_BANKS*DATA_WIDTH-1:0] wr_data;
  logic                            wr_broadcast;
  logic                            wr_done;
  logic                            wr_ready;
  logic                            wr_half;
  logic [NUM_BANKS-1:0]            rd_req;
  logic [NUM_BANKS*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data;
  logic [NUM_BANKS-1:0]            rd_valid;
  logic                            rd_done;
  logic                            rd_ready;
  logic                            rd_half;
  logic                            err_overflow;
  logic                            err_underflow;

  modport master (
    output wr_req, wr_addr, wr_data, wr_broadcast, wr_done,
    output rd_req, rd_addr, rd_done,
    input  wr_ready, wr_half, rd_data, rd_valid, rd_ready, rd_half,
    input  err_overflow, err_underflow
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, wr_broadcast, wr_done,
    input  rd_req, rd_addr, rd_done,
    output wr_ready, wr_half, rd_data, rd_valid, rd_ready, rd_half,
    output err_overflow, err_underflow
  );
endinterface

// File: rtl/ibuf_pingpong.sv
// Banked ping-pong input buffer: writer fills one half while the array reads the other;
// halves swap through wr_done/rd_done, with sticky overflow/underflow flags.
module ibuf_pingpong #(
  parameter int unsigned NUM_BANKS    = 64,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BANK_DEPTH   = 512,
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned READ_LATENCY = 1
) (
  input logic           clk,
  input logic           reset,
  ibuf_pingpong_if.slave bus
);

  typedef enum logic {FREE = 1'b0, FILLED = 1'b1} half_state_e;

  half_state_e half_q [2];
  half_state_e half_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        ovf_q, unf_q;
  logic        wr_ok, rd_ok;

  assign wr_ok = (half_q[wr_ptr_q] == FREE);
  assign rd_ok = (half_q[rd_ptr_q] == FILLED);

  assign bus.wr_ready      = wr_ok;
  assign bus.rd_ready      = rd_ok;
  assign bus.wr_half       = wr_ptr_q;
  assign bus.rd_half       = rd_ptr_q;
  assign bus.err_overflow  = ovf_q;
  assign bus.err_underflow = unf_q;

  // Both dones may land together; they always address different halves.
  always_comb begin
    half_d   = half_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.wr_done && wr_ok) begin
      half_d[wr_ptr_q] = FILLED;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (bus.rd_done && rd_ok) begin
      half_d[rd_ptr_q] = FREE;
      rd_ptr_d         = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      half_q[0] <= FREE;
      half_q[1] <= FREE;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      half_q   <= half_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_q | (~wr_ok & ((|bus.wr_req) | bus.wr_done));
      unf_q    <= unf_q | (~rd_ok & ((|bus.rd_req) | bus.rd_done));
    end
  end

  for (genvar n = 0; n < NUM_BANKS; n++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [2*BANK_DEPTH];
    logic [ADDR_WIDTH-1:0] waddr, raddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] d1_q;
    logic                  v1_q;
    logic                  rd_go;

    assign waddr = bus.wr_broadcast ? bus.wr_addr[0 +: ADDR_WIDTH]
                                    : bus.wr_addr[n*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata = bus.wr_broadcast ? bus.wr_data[0 +: DATA_WIDTH]
                                    : bus.wr_data[n*DATA_WIDTH +: DATA_WIDTH];
    assign raddr = bus.rd_addr[n*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_go = bus.rd_req[n] && rd_ok;

    always_ff @(posedge clk) begin
      if (bus.wr_req[n] && wr_ok) mem[{wr_ptr_q, waddr}] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        v1_q <= 1'b0;
        d1_q <= '0;
      end else begin
        v1_q <= rd_go;
        if (rd_go) d1_q <= mem[{rd_ptr_q, raddr}];
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] d2_q;
      logic                  v2_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          v2_q <= 1'b0;
          d2_q <= '0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) d2_q <= d1_q;
        end
      end
      assign bus.rd_data[n*DATA_WIDTH +: DATA_WIDTH] = d2_q;
      assign bus.rd_valid[n]                         = v2_q;
    end else begin : g_lat1
      assign bus.rd_data[n*DATA_WIDTH +: DATA_WIDTH] = d1_q;
      assign bus.rd_valid[n]                         = v1_q;
    end
  end

endmodule

// File: tb/tb_ibuf_pingpong.sv
// Directed bench for ibuf_pingpong: one READ_LATENCY=1 instance drives the main sequence,
// a READ_LATENCY=2 instance checks the extra output stage.
module tb_ibuf_pingpong;
  localparam int unsigned NB = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned BD = 16;
  localparam int unsigned AW = 4;

  logic clk;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [NB*DW-1:0] exp_v;

  ibuf_pingpong_if #(.NUM_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa ();
  ibuf_pingpong_if #(.NUM_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();

  ibuf_pingpong #(.NUM_BANKS(NB), .DATA_WIDTH(DW), .BANK_DEPTH(BD), .ADDR_WIDTH(AW),
                  .READ_LATENCY(1)) dut_l1 (.clk(clk), .reset(reset), .bus(ifa));
  ibuf_pingpong #(.NUM_BANKS(NB), .DATA_WIDTH(DW), .BANK_DEPTH(BD), .ADDR_WIDTH(AW),
                  .READ_LATENCY(2)) dut_l2 (.clk(clk), .reset(reset), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_a();
    ifa.wr_req = '0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.wr_broadcast = 1'b0;
    ifa.wr_done = 1'b0; ifa.rd_req = '0; ifa.rd_addr = '0; ifa.rd_done = 1'b0;
  endtask

  task automatic idle_b();
    ifb.wr_req = '0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.wr_broadcast = 1'b0;
    ifb.wr_done = 1'b0; ifb.rd_req = '0; ifb.rd_addr = '0; ifb.rd_done = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle_a();
    idle_b();
    tick(); tick();
    chk("rst_wr_ready", 64'(ifa.wr_ready), 64'd1);
    chk("rst_rd_ready", 64'(ifa.rd_ready), 64'd0);
    chk("rst_rd_valid", 64'(ifa.rd_valid), 64'd0);
    chk("rst_rd_data", 64'(ifa.rd_data), 64'd0);
    chk("rst_err_ovf", 64'(ifa.err_overflow), 64'd0);
    chk("rst_err_unf", 64'(ifa.err_underflow), 64'd0);
    reset = 1'b1;
    tick();

    // Single write bank 3 addr 5, hand over, read back
    ifa.wr_req = 8'h08; ifa.wr_addr[3*AW +: AW] = 4'd5; ifa.wr_data[3*DW +: DW] = 8'hA5;
    tick();
    idle_a(); ifa.wr_done = 1'b1;
    tick();
    chk("swap1_wr_half", 64'(ifa.wr_half), 64'd1);
    chk("swap1_wr_ready", 64'(ifa.wr_ready), 64'd1);
    chk("swap1_rd_ready", 64'(ifa.rd_ready), 64'd1);
    chk("swap1_rd_half", 64'(ifa.rd_half), 64'd0);
    idle_a(); ifa.rd_req = 8'h08; ifa.rd_addr[3*AW +: AW] = 4'd5;
    tick();
    chk("rd1_valid", 64'(ifa.rd_valid), 64'h08);
    chk("rd1_data", 64'(ifa.rd_data[31:24]), 64'hA5);
    idle_a();
    tick();
    chk("rd1_valid_drop", 64'(ifa.rd_valid), 64'd0);
    chk("rd1_data_hold", 64'(ifa.rd_data[31:24]), 64'hA5);
    ifa.rd_done = 1'b1;
    tick();
    idle_a();
    chk("free0_rd_ready", 64'(ifa.rd_ready), 64'd0);
    chk("free0_rd_half", 64'(ifa.rd_half), 64'd1);

    // Fill half 1: lane n addr n = 0x10+n
    ifa.wr_req = '1;
    for (int n = 0; n < NB; n++) begin
      ifa.wr_addr[n*AW +: AW] = AW'(n);
      ifa.wr_data[n*DW +: DW] = 8'h10 + 8'(n);
    end
    tick();
    idle_a(); ifa.wr_done = 1'b1;
    tick();
    idle_a();
    chk("fill1_rd_ready", 64'(ifa.rd_ready), 64'd1);
    chk("fill1_wr_half", 64'(ifa.wr_half), 64'd0);

    // Overlap: fill half 0 with 0x20+n while reading half 1
    ifa.wr_req = '1; ifa.rd_req = '1;
    for (int n = 0; n < NB; n++) begin
      ifa.wr_addr[n*AW +: AW] = AW'(n);
      ifa.wr_data[n*DW +: DW] = 8'h20 + 8'(n);
      ifa.rd_addr[n*AW +: AW] = AW'(n);
      exp_v[n*DW +: DW] = 8'h10 + 8'(n);
    end
    tick();
    chk("ovl_valid", 64'(ifa.rd_valid), 64'hFF);
    chk("ovl_data", 64'(ifa.rd_data), 64'(exp_v));
    ifa.wr_req = '0; ifa.wr_done = 1'b1; ifa.rd_done = 1'b1;
    tick();
    chk("dual_done_valid", 64'(ifa.rd_valid), 64'hFF);
    chk("dual_done_data", 64'(ifa.rd_data), 64'(exp_v));
    chk("dual_done_wr_half", 64'(ifa.wr_half), 64'd1);
    chk("dual_done_rd_half", 64'(ifa.rd_half), 64'd0);
    ifa.wr_done = 1'b0; ifa.rd_done = 1'b0;
    for (int n = 0; n < NB; n++) exp_v[n*DW +: DW] = 8'h20 + 8'(n);
    tick();
    chk("half0_valid", 64'(ifa.rd_valid), 64'hFF);
    chk("half0_data", 64'(ifa.rd_data), 64'(exp_v));
    idle_a();
    tick();
    chk("ovl_valid_drop", 64'(ifa.rd_valid), 64'd0);
    chk("ovl_err_ovf", 64'(ifa.err_overflow), 64'd0);
    chk("ovl_err_unf", 64'(ifa.err_underflow), 64'd0);

    // Broadcast into half 1; other lanes carry decoy addr/data
    ifa.wr_broadcast = 1'b1; ifa.wr_req = '1;
    for (int n = 1; n < NB; n++) begin
      ifa.wr_addr[n*AW +: AW] = 4'hF;
      ifa.wr_data[n*DW +: DW] = 8'hEE;
    end
    ifa.wr_addr[0 +: AW] = 4'd7; ifa.wr_data[0 +: DW] = 8'h3C;
    tick();
    idle_a(); ifa.wr_done = 1'b1;
    tick();
    idle_a();
    chk("both_full_wr_ready", 64'(ifa.wr_ready), 64'd0);
    ifa.rd_done = 1'b1;
    tick();
    idle_a();
    chk("bc_release_wr_ready", 64'(ifa.wr_ready), 64'd1);
    ifa.rd_req = '1;
    for (int n = 0; n < NB; n++) ifa.rd_addr[n*AW +: AW] = 4'd7;
    tick();
    chk("bc_valid", 64'(ifa.rd_valid), 64'hFF);
    chk("bc_data", 64'(ifa.rd_data), 64'h3C3C_3C3C_3C3C_3C3C);

    // Back-pressure: write half 0 with wr_done in the same cycle, then overrun
    idle_a(); ifa.wr_req = '1; ifa.wr_done = 1'b1;
    for (int n = 0; n < NB; n++) begin
      ifa.wr_addr[n*AW +: AW] = 4'd9;
      ifa.wr_data[n*DW +: DW] = 8'h50 + 8'(n);
    end
    tick();
    chk("bp_wr_ready", 64'(ifa.wr_ready), 64'd0);
    chk("bp_wr_half", 64'(ifa.wr_half), 64'd1);
    chk("bp_err_ovf_clear", 64'(ifa.err_overflow), 64'd0);
    ifa.wr_req = '1; ifa.wr_done = 1'b1;
    for (int n = 0; n < NB; n++) begin
      ifa.wr_addr[n*AW +: AW] = 4'd7;
      ifa.wr_data[n*DW +: DW] = 8'h99;
    end
    tick();
    idle_a();
    chk("ovf_flag", 64'(ifa.err_overflow), 64'd1);
    chk("ovf_wr_half", 64'(ifa.wr_half), 64'd1);
    chk("ovf_wr_ready", 64'(ifa.wr_ready), 64'd0);
    ifa.rd_req = '1; ifa.rd_done = 1'b1;
    for (int n = 0; n < NB; n++) ifa.rd_addr[n*AW +: AW] = 4'd7;
    tick();
    idle_a();
    chk("ovf_dropped_data", 64'(ifa.rd_data), 64'h3C3C_3C3C_3C3C_3C3C);
    chk("ovf_rd_half", 64'(ifa.rd_half), 64'd0);
    ifa.rd_req = '1;
    for (int n = 0; n < NB; n++) begin
      ifa.rd_addr[n*AW +: AW] = 4'd9;
      exp_v[n*DW +: DW] = 8'h50 + 8'(n);
    end
    ifa.rd_addr[3*AW +: AW] = 4'd5;
    exp_v[3*DW +: DW] = 8'hA5;
    tick();
    chk("half0_kept_data", 64'(ifa.rd_data), 64'(exp_v));
    chk("bp_err_unf", 64'(ifa.err_underflow), 64'd0);

    // Reset during streaming reads
    tick();
    chk("stream_valid", 64'(ifa.rd_valid), 64'hFF);
    reset = 1'b0;
    #1;
    chk("async_rst_valid", 64'(ifa.rd_valid), 64'd0);
    chk("async_rst_data", 64'(ifa.rd_data), 64'd0);
    tick();
    idle_a();
    reset = 1'b1;
    #1;
    chk("post_rst_wr_ready", 64'(ifa.wr_ready), 64'd1);
    chk("post_rst_rd_ready", 64'(ifa.rd_ready), 64'd0);
    chk("post_rst_wr_half", 64'(ifa.wr_half), 64'd0);
    chk("post_rst_err_ovf", 64'(ifa.err_overflow), 64'd0);

    // Underflow straight after reset
    ifa.rd_req = '1; ifa.rd_done = 1'b1;
    tick();
    idle_a();
    chk("unf_valid", 64'(ifa.rd_valid), 64'd0);
    chk("unf_flag", 64'(ifa.err_underflow), 64'd1);
    chk("unf_rd_half", 64'(ifa.rd_half), 64'd0);
    tick();
    chk("unf_valid_late", 64'(ifa.rd_valid), 64'd0);

    // READ_LATENCY=2 instance
    ifb.wr_req = 8'h02; ifb.wr_addr[1*AW +: AW] = 4'd2; ifb.wr_data[1*DW +: DW] = 8'h5A;
    tick();
    idle_b(); ifb.wr_done = 1'b1;
    tick();
    idle_b(); ifb.rd_req = 8'h02; ifb.rd_addr[1*AW +: AW] = 4'd2;
    tick();
    idle_b();
    chk("l2_valid_cycle1", 64'(ifb.rd_valid), 64'd0);
    tick();
    chk("l2_valid_cycle2", 64'(ifb.rd_valid), 64'h02);
    chk("l2_data_cycle2", 64'(ifb.rd_data[15:8]), 64'h5A);
    tick();
    chk("l2_valid_drop", 64'(ifb.rd_valid), 64'd0);
    chk("l2_data_hold", 64'(ifb.rd_data[15:8]), 64'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
